// File: rtl/aes256_key_expander_if.sv
// Purpose: bundles the request, round-key stream and table-read signals of the AES-256 key expander.
// Latency: none (wires only); the expander defines all timing.
// Backpressure: none; the round-key stream is a strobe that the consumer must take when rk_valid=1.
//
// Signals: start/key_in (request), busy/done (status), rk_valid/rk_idx/rk_out (round-key stream),
//          rd_idx/rd_key (combinational table read port).
interface aes256_key_expander_if;
  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  // master: the block that requests expansion and consumes round keys
  modport master (
    output start, key_in, rd_idx,
    input  busy, rk_valid, rk_idx, rk_out, done, rd_key
  );

  // slave: the key expander itself
  modport slave (
    input  start, key_in, rd_idx,
    output busy, rk_valid, rk_idx, rk_out, done, rd_key
  );
endinterface

// File: rtl/aes256_key_expander.sv
// Purpose: sequential AES-256 key schedule, one 32-bit word per clock, 15 round keys streamed and tabled.
// Latency: rk0 after start edge E0, rk1 after E1, rk n after E(4n-3); rk14 and done after E53.
// Backpressure: none; start is ignored while busy, round keys are one-cycle strobes.
//
// Ports: clk, rst (async active-low), kif (slave modport): start/key_in in, busy/done out,
//        rk_valid/rk_idx/rk_out stream out, rd_idx in / rd_key out (combinational table read).
module aes256_key_expander #(
  parameter int KEY_W = 256,
  parameter int RK_W  = 128,
  parameter int NR    = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  aes256_key_expander_if.slave     kif
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  typedef enum logic [1:0] {IDLE, EMIT1, EXPAND} state_t;

  state_t          state, state_nxt;
  logic            load, emit1, expand;
  logic [31:0]     w [8];           // sliding window: w[0] = w[i-8] ... w[7] = w[i-1]
  logic [5:0]      i;               // index of the word computed on the next EXPAND edge
  logic [RK_W-1:0] table_q [NR+1];
  logic            busy_q, done_q, rk_valid_q;
  logic [3:0]      rk_idx_q;
  logic [RK_W-1:0] rk_out_q;
  logic [31:0]     temp, w_new;
  logic [7:0]      rcon;
  logic [RK_W-1:0] rk_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    emit1     = 1'b0;
    expand    = 1'b0;
    case (state)
      IDLE:    if (kif.start) begin
                 load      = 1'b1;
                 state_nxt = EMIT1;
               end
      EMIT1:   begin
                 emit1     = 1'b1;
                 state_nxt = EXPAND;
               end
      EXPAND:  begin
                 expand = 1'b1;
                 if (i == 6'd59) state_nxt = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  // Next schedule word. i/8 selects Rcon; i%8 picks the RotWord+SubWord or SubWord-only step.
  always_comb begin
    rcon = 8'h01 << (i[5:3] - 3'd1);
    temp = w[7];
    if (i[2:0] == 3'd0)      temp = sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
    else if (i[2:0] == 3'd4) temp = sub_word(w[7]);
    w_new   = w[0] ^ temp;
    rk_word = {w[5], w[6], w[7], w_new};   // w[i-3..i]
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) w[k] <= '0;
      for (int k = 0; k < NR + 1; k++) table_q[k] <= '0;
      i          <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_idx_q   <= '0;
      rk_out_q   <= '0;
    end else begin
      rk_valid_q <= 1'b0;
      if (load) begin
        for (int k = 0; k < 8; k++) w[k] <= kif.key_in[KEY_W-1-32*k -: 32];
        i          <= 6'd8;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        rk_valid_q <= 1'b1;
        rk_idx_q   <= 4'd0;
        rk_out_q   <= kif.key_in[KEY_W-1 -: RK_W];
        table_q[0] <= kif.key_in[KEY_W-1 -: RK_W];
      end
      if (emit1) begin
        // window still holds the raw key, so words 4..7 are its second half
        rk_valid_q <= 1'b1;
        rk_idx_q   <= 4'd1;
        rk_out_q   <= {w[4], w[5], w[6], w[7]};
        table_q[1] <= {w[4], w[5], w[6], w[7]};
      end
      if (expand) begin
        for (int k = 0; k < 7; k++) w[k] <= w[k+1];
        w[7] <= w_new;
        i    <= i + 6'd1;
        if (i[1:0] == 2'd3) begin
          // (i-3)/4 when i%4==3 is simply i[5:2]
          rk_valid_q       <= 1'b1;
          rk_idx_q         <= i[5:2];
          rk_out_q         <= rk_word;
          table_q[i[5:2]]  <= rk_word;
        end
        if (i == 6'd59) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign kif.busy     = busy_q;
  assign kif.done     = done_q;
  assign kif.rk_valid = rk_valid_q;
  assign kif.rk_idx   = rk_idx_q;
  assign kif.rk_out   = rk_out_q;
  assign kif.rd_key   = (kif.rd_idx <= 4'(NR)) ? table_q[kif.rd_idx] : '0;

endmodule

// File: tb/tb_aes256_key_expander.sv
// Purpose: self-checking bench for aes256_key_expander (known-answer vectors plus random keys vs a reference model).
// Latency: checks every cycle of each 54-cycle expansion, sampled 1 time unit after the rising edge.
// Backpressure: n/a; the bench drives start/key_in/rd_idx and observes the stream and table.
module tb_aes256_key_expander;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes256_key_expander_if kif ();

  aes256_key_expander dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [15];
  logic [127:0] model_tbl [15];
  logic [127:0] cap [4][15];

  localparam logic [255:0] KEY_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_ZERO = '0;
  localparam logic [255:0] KEY_ONES = '1;

  typedef struct {
    int           slot;   // which captured run
    int           idx;    // round index
    logic [127:0] rk;     // known-answer round key
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---- reference model: S-box derived from GF(2^8) inverse + affine map ----
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] vb  = 8'(v);
      for (int c = 1; c < 256; c++)
        if (gmul(vb, 8'(c)) == 8'h01) inv = 8'(c);
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
  endfunction

  // Plain FIPS-197 KeyExpansion over a 60-word array.
  task automatic model_expand(input logic [255:0] key);
    logic [31:0] wm [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int k = 0; k < 8; k++) wm[k] = key[255-32*k -: 32];
    for (int n = 8; n < 60; n++) begin
      t = wm[n-1];
      if (n % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (n % 8 == 4) begin
        t = subw(t);
      end
      wm[n] = wm[n-8] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},     128'(kif.busy),     128'd0);
    chk({tag, "_rk_valid"}, 128'(kif.rk_valid), 128'd0);
    chk({tag, "_rk_idx"},   128'(kif.rk_idx),   128'd0);
    chk({tag, "_rk_out"},   kif.rk_out,         128'd0);
    chk({tag, "_done"},     128'(kif.done),     128'd0);
  endtask

  // One expansion, checked cycle by cycle from start edge E0 to E53.
  // glitch_at: cycle at which a bogus start is pulsed; hold: start stays high throughout;
  // rst_at: cycle after which reset is asserted (run aborts); slot: capture slot (-1 = none).
  task automatic run(input logic [255:0] key, input int glitch_at, input bit hold,
                     input int rst_at, input int slot);
    bit           exp_v;
    int           exp_i;
    logic [127:0] last_rk;
    int           last_i;
    model_expand(key);
    last_rk = kif.rk_out;
    last_i  = int'(kif.rk_idx);
    for (int c = 0; c <= 53; c++) begin
      if (c == 0) begin
        kif.start  = 1'b1;
        kif.key_in = key;
      end else if (hold || c == glitch_at) begin
        kif.start  = 1'b1;
        kif.key_in = ~key;
      end else begin
        kif.start  = 1'b0;
        kif.key_in = rand_key();
      end
      kif.rd_idx = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      exp_v = (c == 0) || (c == 1) || (c >= 5 && (c - 1) % 4 == 0);
      exp_i = (c <= 1) ? c : (c + 3) / 4;
      if (exp_v) begin
        model_tbl[exp_i] = exp_rk[exp_i];
        last_rk = exp_rk[exp_i];
        last_i  = exp_i;
        if (slot >= 0) cap[slot][exp_i] = kif.rk_out;
      end
      chk("rk_valid", 128'(kif.rk_valid), 128'(exp_v));
      chk("rk_idx",   128'(kif.rk_idx),   128'(last_i));
      chk("rk_out",   kif.rk_out,         last_rk);
      chk("busy",     128'(kif.busy),     128'(c < 53));
      chk("done",     128'(kif.done),     128'(c == 53));
      chk("rd_key",   kif.rd_key, (kif.rd_idx < 4'd15) ? model_tbl[kif.rd_idx] : 128'd0);
      if (c == rst_at) begin
        rst = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        for (int r = 0; r < 15; r++) model_tbl[r] = '0;
        kif.start = 1'b0;
        return;
      end
    end
    kif.start = 1'b0;
  endtask

  task automatic sweep_table();
    kif.start = 1'b0;
    for (int r = 0; r < 16; r++) begin
      kif.rd_idx = 4'(r);
      @(posedge clk);
      #1;
      chk("table_sweep", kif.rd_key, (r < 15) ? model_tbl[r] : 128'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{0, 0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{0, 1,  128'h101112131415161718191a1b1c1d1e1f};
    vecs[2] = '{0, 2,  128'ha573c29fa176c498a97fce93a572c09c};
    vecs[3] = '{0, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[4] = '{1, 0,  128'h0};
    vecs[5] = '{1, 2,  128'h62636363626363636263636362636363};
    vecs[6] = '{2, 0,  128'hffffffffffffffffffffffffffffffff};
    vecs[7] = '{2, 1,  128'hffffffffffffffffffffffffffffffff};

    rst        = 1'b0;
    kif.start  = 1'b0;
    kif.key_in = '0;
    kif.rd_idx = 4'd0;
    for (int r = 0; r < 15; r++) model_tbl[r] = '0;
    build_sbox();
    #1;
    check_outputs_zero("reset");
    chk("reset_rd_key", kif.rd_key, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 key with a bogus start at E10 that must be ignored, then table readback
    run(KEY_C3, 10, 1'b0, -1, 0);
    sweep_table();

    // zero key, then all-ones back-to-back (start held high all the way), then a random key back-to-back
    run(KEY_ZERO, -1, 1'b0, -1, 1);
    run(KEY_ONES, -1, 1'b1, -1, 2);
    run(rand_key(), -1, 1'b0, -1, 3);
    sweep_table();

    // reset mid-expansion, table must be cleared, then a clean schedule
    run(rand_key(), -1, 1'b0, 20, -1);
    for (int r = 0; r < 16; r++) begin
      kif.rd_idx = 4'(r);
      #1;
      chk("rst_table", kif.rd_key, 128'd0);
    end
    @(posedge clk);
    #1;
    check_outputs_zero("rst_hold");
    rst = 1'b1;
    @(posedge clk);
    #1;
    run(rand_key(), -1, 1'b0, -1, 3);
    run(KEY_C3, -1, 1'b0, -1, -1);
    sweep_table();

    // known-answer comparisons of the captured streams
    for (int v = 0; v < 8; v++)
      chk($sformatf("kat_slot%0d_rk%0d", vecs[v].slot, vecs[v].idx), cap[vecs[v].slot][vecs[v].idx], vecs[v].rk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
